// File: rtl/calc_controller_if.sv
// Bundle of start/status, operand-memory, adder and result-memory signals around the
// calc controller. master = the controller, slave = the surrounding datapath.
interface calc_controller_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
);
  logic              start_i;
  logic [ADDR_W-1:0] read_start_addr_i;
  logic [ADDR_W-1:0] read_end_addr_i;
  logic [ADDR_W-1:0] write_start_addr_i;
  logic              rd_en_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [DATA_W-1:0] rd_data_i;
  logic [DATA_W-1:0] op_a_o;
  logic [DATA_W-1:0] op_b_o;
  logic [DATA_W-1:0] sum_i;
  logic              wr_en_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic              busy_o;
  logic              done_o;
  logic              ovf_o;

  modport master (
    input  start_i, read_start_addr_i, read_end_addr_i, write_start_addr_i, rd_data_i, sum_i,
    output rd_en_o, rd_addr_o, op_a_o, op_b_o, wr_en_o, wr_addr_o, wr_data_o,
    output busy_o, done_o, ovf_o
  );

  modport slave (
    output start_i, read_start_addr_i, read_end_addr_i, write_start_addr_i, rd_data_i, sum_i,
    input  rd_en_o, rd_addr_o, op_a_o, op_b_o, wr_en_o, wr_addr_o, wr_data_o,
    input  busy_o, done_o, ovf_o
  );
endinterface

// File: rtl/calc_controller.sv
// Streams operand pairs from memory through the adder into result memory.
// Optional sticky unsigned-overflow flag: define CALC_OVERFLOW_FLAG_EN.
module calc_controller #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10
) (
  input logic               clk_i,
  input logic               rst_ni,
  calc_controller_if.master bus
);

  typedef enum logic [2:0] {StIdle, StReadA, StReadB, StCaptureB, StWrite, StDone} state_e;

  localparam logic [ADDR_W:0]   ExtOne   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   ExtThree = {{(ADDR_W-1){1'b0}}, 2'b11};
  localparam logic [ADDR_W-1:0] AddrOne  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] AddrTwo  = {{(ADDR_W-2){1'b0}}, 2'b10};

  state_e            r_state;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_end;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_rd_en;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_busy;
  logic              r_done;

  logic w_empty;
  logic w_more;

  // Extra top bit keeps the end compares correct at the top of the address space.
  assign w_empty = {1'b0, bus.read_end_addr_i} < ({1'b0, bus.read_start_addr_i} + ExtOne);
  assign w_more  = ({1'b0, r_rd_ptr} + ExtThree) <= {1'b0, r_rd_end};

`ifdef CALC_OVERFLOW_FLAG_EN
  logic r_ovf;
  assign bus.ovf_o = r_ovf;
`else
  assign bus.ovf_o = 1'b0;
`endif

  // Outputs are registered: each state loads the output values of the state it enters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_rd_end  <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef CALC_OVERFLOW_FLAG_EN
      r_ovf     <= 1'b0;
`endif
    end else begin
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_done    <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (bus.start_i) begin
            r_rd_ptr <= bus.read_start_addr_i;
            r_wr_ptr <= bus.write_start_addr_i;
            r_rd_end <= bus.read_end_addr_i;
            r_busy   <= 1'b1;
`ifdef CALC_OVERFLOW_FLAG_EN
            r_ovf    <= 1'b0;
`endif
            if (w_empty) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state   <= StReadA;
              r_rd_en   <= 1'b1;
              r_rd_addr <= bus.read_start_addr_i;
            end
          end
        end
        StReadA: begin
          r_state   <= StReadB;
          r_rd_en   <= 1'b1;
          r_rd_addr <= r_rd_ptr + AddrOne;
        end
        StReadB: begin
          r_op_a  <= bus.rd_data_i;
          r_state <= StCaptureB;
        end
        StCaptureB: begin
          r_op_b    <= bus.rd_data_i;
          r_state   <= StWrite;
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_wr_ptr;
        end
        StWrite: begin
`ifdef CALC_OVERFLOW_FLAG_EN
          if (bus.sum_i < r_op_a) r_ovf <= 1'b1;
`endif
          r_rd_ptr <= r_rd_ptr + AddrTwo;
          r_wr_ptr <= r_wr_ptr + AddrOne;
          if (w_more) begin
            r_state   <= StReadA;
            r_rd_en   <= 1'b1;
            r_rd_addr <= r_rd_ptr + AddrTwo;
          end else begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rd_en_o   = r_rd_en;
  assign bus.rd_addr_o = r_rd_addr;
  assign bus.op_a_o    = r_op_a;
  assign bus.op_b_o    = r_op_b;
  assign bus.wr_en_o   = r_wr_en;
  assign bus.wr_addr_o = r_wr_addr;
  assign bus.wr_data_o = r_wr_en ? bus.sum_i : '0;
  assign bus.busy_o    = r_busy;
  assign bus.done_o    = r_done;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: memory and adder models plus a write scoreboard.
module tb_calc_controller;

  logic clk;
  logic rst_n;

  calc_controller_if #(.DATA_W(32), .ADDR_W(10)) bus ();

  calc_controller #(.DATA_W(32), .ADDR_W(10)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  logic [31:0] mem [0:1023];
  logic [31:0] rd_data_r;
  logic [41:0] sb [$];
  int          n_pass  = 0;
  int          n_total = 0;
  int          wr_cnt  = 0;
  int          rd_cnt  = 0;
  logic [9:0]  cur_rs  = '0;
  logic [9:0]  cur_re  = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (bus.rd_en_o) rd_data_r <= mem[bus.rd_addr_o];
  assign bus.rd_data_i = rd_data_r;
  assign bus.sum_i     = bus.op_a_o + bus.op_b_o;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en_o) begin
        rd_cnt++;
        check("rd_in_range", 64'(bus.rd_addr_o >= cur_rs && bus.rd_addr_o <= cur_re), 64'd1);
      end else begin
        check("rd_addr_idle", 64'(bus.rd_addr_o), 64'd0);
      end
      if (bus.wr_en_o) begin
        logic [41:0] e;
        wr_cnt++;
        check("write_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("wr_addr", 64'(bus.wr_addr_o), 64'(e[41:32]));
          check("wr_data", 64'(bus.wr_data_o), 64'(e[31:0]));
        end
      end else begin
        check("wr_data_idle", 64'(bus.wr_data_o), 64'd0);
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_busy"},  64'(bus.busy_o),    64'd0);
    check({tag, "_done"},  64'(bus.done_o),    64'd0);
    check({tag, "_rden"},  64'(bus.rd_en_o),   64'd0);
    check({tag, "_rdadr"}, 64'(bus.rd_addr_o), 64'd0);
    check({tag, "_wren"},  64'(bus.wr_en_o),   64'd0);
    check({tag, "_wradr"}, 64'(bus.wr_addr_o), 64'd0);
    check({tag, "_wrdat"}, 64'(bus.wr_data_o), 64'd0);
    check({tag, "_opa"},   64'(bus.op_a_o),    64'd0);
    check({tag, "_opb"},   64'(bus.op_b_o),    64'd0);
    check({tag, "_ovf"},   64'(bus.ovf_o),     64'd0);
  endtask

  // Push expected writes for pairs [0, npush), then start.
  task automatic push_and_start(input logic [9:0] rs, re, ws, input int npush);
    for (int p = 0; p < npush; p++) begin
      logic [9:0]  ai;
      logic [9:0]  wa;
      logic [31:0] d;
      ai = rs + 10'(2 * p);
      wa = ws + 10'(p);
      d  = mem[ai] + mem[ai + 10'd1];
      sb.push_back({wa, d});
    end
    cur_rs = rs;
    cur_re = re;
    @(negedge clk);
    bus.start_i            = 1'b1;
    bus.read_start_addr_i  = rs;
    bus.read_end_addr_i    = re;
    bus.write_start_addr_i = ws;
    @(posedge clk);
    #1;
    bus.start_i            = 1'b0;
    bus.read_start_addr_i  = 10'h3C5;
    bus.read_end_addr_i    = 10'h011;
    bus.write_start_addr_i = 10'h2AA;
  endtask

  task automatic run(input string tag, input logic [9:0] rs, re, ws, input int pulse_at);
    int n;
    int lat;
    int busy_cnt;
    int wr0;
    int rd0;
    n = ({1'b0, re} < ({1'b0, rs} + 11'd1)) ? 0 : (int'(re) - int'(rs) + 1) / 2;
    lat = -1;
    busy_cnt = 0;
    wr0 = wr_cnt;
    rd0 = rd_cnt;
    push_and_start(rs, re, ws, n);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (bus.busy_o) busy_cnt++;
      bus.start_i = (cyc == pulse_at);
      if (bus.done_o) begin
        lat = cyc;
        break;
      end
    end
    bus.start_i = 1'b0;
    check({tag, "_done_lat"}, 64'(lat), 64'(4 * n + 1));
    check({tag, "_busy_cyc"}, 64'(busy_cnt), 64'(4 * n + 1));
    check({tag, "_writes"}, 64'(wr_cnt - wr0), 64'(n));
    check({tag, "_reads"}, 64'(rd_cnt - rd0), 64'(2 * n));
    check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(bus.done_o), 64'd0);
    check({tag, "_idle_busy"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    int found;
    int wr0;
    bus.start_i            = 1'b0;
    bus.read_start_addr_i  = '0;
    bus.read_end_addr_i    = '0;
    bus.write_start_addr_i = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    rst_n = 1'b0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    mem[0] = 32'd5;
    mem[1] = 32'd7;
    run("single", 10'd0, 10'd1, 10'h100, 0);

    mem[4] = 32'd1;
    mem[5] = 32'd2;
    mem[6] = 32'd3;
    mem[7] = 32'd4;
    mem[8] = 32'hFFFF_FFFF;
    mem[9] = 32'd1;
    run("three", 10'd4, 10'd9, 10'h20, 0);
`ifdef CALC_OVERFLOW_FLAG_EN
    check("three_ovf", 64'(bus.ovf_o), 64'd1);
`else
    check("three_ovf", 64'(bus.ovf_o), 64'd0);
`endif

    run("empty", 10'd8, 10'd8, 10'h30, 0);
    check("empty_ovf_clr", 64'(bus.ovf_o), 64'd0);

    mem[2] = 32'hDEAD_BEEF;
    run("odd", 10'd0, 10'd2, 10'h40, 0);

    mem[1022] = 32'd100;
    mem[1023] = 32'd200;
    run("top", 10'd1022, 10'd1023, 10'h50, 0);

    mem[10] = 32'h1000_0000;
    mem[11] = 32'h0000_0001;
    mem[12] = 32'h0000_0042;
    mem[13] = 32'h0000_0100;
    run("busy_start", 10'd10, 10'd13, 10'h60, 2);

    mem[20] = 32'd11;
    mem[21] = 32'd22;
    mem[22] = 32'd33;
    mem[23] = 32'd44;
    wr0 = wr_cnt;
    push_and_start(10'd20, 10'd23, 10'h70, 1);
    found = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      @(negedge clk);
      if (bus.wr_en_o) begin
        found = 1;
        break;
      end
    end
    check("abort_reached_write", 64'(found), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("abort");
    repeat (3) @(negedge clk);
    check("abort_writes", 64'(wr_cnt - wr0), 64'd1);
    check("abort_sb_empty", 64'(sb.size()), 64'd0);
    rst_n = 1'b1;
    run("after_abort", 10'd20, 10'd23, 10'h70, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
